// File: rtl/iic_slave.sv
// I2C target on the TRSQ8 byte bus: own-address match, single-byte RX/TX holding registers.
// Define IICS_CLK_STRETCH_EN to hold SCL low instead of discarding RX bytes or sending 8'hFF.
module iic_slave #(
  parameter logic [7:0] BASE_ADDR = 8'h84,
  parameter logic [7:0] LAST_ADDR = 8'h87
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] addr,
  input  logic [7:0] dout,
  output logic [7:0] din,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl_oe
);
`ifdef IICS_CLK_STRETCH_EN
  localparam bit Stretch = 1'b1;
`else
  localparam bit Stretch = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE} state_e;

  state_e     state_q;
  logic       scl_s1_q, scl_s2_q, scl_dl_q, sda_s1_q, sda_s2_q, sda_dl_q;
  logic       en_q, ack_en_q, addressed_q, rw_q, rx_full_q, tx_empty_q, stop_seen_q, overrun_q;
  logic [6:0] own_q;
  logic [7:0] tx_q, rx_q, shift_q, din_q, rd_data_d;
  logic [3:0] bitcnt_q;
  logic       sda_oe_q, scl_oe_q;
  logic       in_win, scl_rise, scl_fall, start_det, stop_det, tx_wr;

  assign in_win    = (addr >= BASE_ADDR) && (addr <= LAST_ADDR);
  assign din       = in_win ? din_q : 8'hzz;
  assign sda_oe    = sda_oe_q;
  assign scl_oe    = scl_oe_q;
  assign scl_rise  = scl_s2_q & ~scl_dl_q;
  assign scl_fall  = ~scl_s2_q & scl_dl_q;
  assign start_det = scl_s2_q & scl_dl_q & sda_dl_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_dl_q & ~sda_dl_q & sda_s2_q;
  assign tx_wr     = wr_en && in_win && (addr[1:0] == 2'd2);

  always_comb begin
    rd_data_d = '0;
    case (addr[1:0])
      2'd0: rd_data_d = {overrun_q, stop_seen_q, tx_empty_q, rx_full_q,
                         rw_q, addressed_q, ack_en_q, en_q};
      2'd1: rd_data_d = {1'b0, own_q};
      2'd2: rd_data_d = tx_q;
      default: rd_data_d = rx_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      {scl_s1_q, scl_s2_q, scl_dl_q, sda_s1_q, sda_s2_q, sda_dl_q} <= '1;
      {en_q, ack_en_q, addressed_q, rw_q, rx_full_q, stop_seen_q, overrun_q} <= '0;
      tx_empty_q <= 1'b1;
      own_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      shift_q    <= '0;
      din_q      <= '0;
      bitcnt_q   <= '0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
    end else begin
      scl_s1_q <= scl_i;    scl_s2_q <= scl_s1_q; scl_dl_q <= scl_s2_q;
      sda_s1_q <= sda_i;    sda_s2_q <= sda_s1_q; sda_dl_q <= sda_s2_q;

      if (wr_en && in_win) begin
        case (addr[1:0])
          2'd0: begin
            en_q     <= dout[0];
            ack_en_q <= dout[1];
            if (dout[6]) stop_seen_q <= 1'b0;
            if (dout[7]) overrun_q   <= 1'b0;
          end
          2'd1:    own_q <= dout[6:0];
          2'd2:    tx_q  <= dout;
          default: ;
        endcase
      end else if (rd_en && in_win) begin
        din_q <= rd_data_d;
        if (addr[1:0] == 2'd3) rx_full_q <= 1'b0;
      end

      // Bus events override CPU side effects assigned above in the same cycle.
      if (!en_q) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        scl_oe_q <= 1'b0;
      end else if (start_det) begin
        state_q  <= ADDR;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
        scl_oe_q <= 1'b0;
      end else if (stop_det) begin
        state_q     <= IDLE;
        sda_oe_q    <= 1'b0;
        scl_oe_q    <= 1'b0;
        addressed_q <= 1'b0;
        if (addressed_q) stop_seen_q <= 1'b1;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise) begin
              shift_q  <= {shift_q[6:0], sda_s2_q};
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall && bitcnt_q == 4'd8) begin
              if (shift_q[7:1] == own_q && ack_en_q) begin
                addressed_q <= 1'b1;
                rw_q        <= shift_q[0];
                sda_oe_q    <= 1'b1;
                state_q     <= ADDR_ACK;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= '0;
              if (!rw_q) begin
                state_q <= RX;
              end else begin
                state_q <= TX;
                if (Stretch && tx_empty_q) begin
                  scl_oe_q <= 1'b1;
                end else begin
                  shift_q    <= tx_q;
                  tx_empty_q <= 1'b1;
                  sda_oe_q   <= ~tx_q[7];
                end
              end
            end
          end
          RX: begin
            if (scl_rise && !scl_oe_q) begin
              shift_q  <= {shift_q[6:0], sda_s2_q};
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if ((scl_fall && bitcnt_q == 4'd8) || scl_oe_q) begin
              if (!rx_full_q) begin
                rx_q      <= shift_q;
                rx_full_q <= 1'b1;
                sda_oe_q  <= ack_en_q;
                scl_oe_q  <= 1'b0;
                state_q   <= RX_ACK;
              end else if (Stretch) begin
                scl_oe_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
                sda_oe_q  <= 1'b0;
                state_q   <= RX_ACK;
              end
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= '0;
              state_q  <= RX;
            end
          end
          TX: begin
            // A stretched load completes once the CPU has refilled IICSTX.
            if (scl_oe_q) begin
              if (!tx_empty_q) begin
                shift_q    <= tx_q;
                tx_empty_q <= 1'b1;
                sda_oe_q   <= ~tx_q[7];
                scl_oe_q   <= 1'b0;
              end
            end else if (scl_fall) begin
              if (bitcnt_q == 4'd7) begin
                sda_oe_q <= 1'b0;
                state_q  <= TX_ACK;
              end else begin
                bitcnt_q <= bitcnt_q + 4'd1;
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              shift_q[0] <= sda_s2_q;
            end else if (scl_fall) begin
              bitcnt_q <= '0;
              if (shift_q[0]) begin
                state_q <= IGNORE;
              end else begin
                state_q <= TX;
                if (tx_empty_q) begin
                  if (Stretch) begin
                    scl_oe_q <= 1'b1;
                  end else begin
                    shift_q   <= 8'hFF;
                    overrun_q <= 1'b1;
                    sda_oe_q  <= 1'b0;
                  end
                end else begin
                  shift_q    <= tx_q;
                  tx_empty_q <= 1'b1;
                  sda_oe_q   <= ~tx_q[7];
                end
              end
            end
          end
          IGNORE:  sda_oe_q <= 1'b0;
          default: ;
        endcase
      end

      if (tx_wr) tx_empty_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: bit-banged I2C master plus CPU accesses, scoreboard-checked.
module tb_iic_slave;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] addr, dout;
  wire  [7:0] din;
  logic       wr_en, rd_en;
  logic       sda_oe, scl_oe;
  logic       m_scl, m_sda;
  wire        scl_line = ~(m_scl | scl_oe);
  wire        sda_line = ~(m_sda | sda_oe);

  int unsigned n_chk = 0, n_pass = 0, n_fail = 0;
  int unsigned oe_cnt = 0;
  logic [7:0]  exp_q[$];
  string       tag_q[$];

  iic_slave #(.BASE_ADDR(8'h84), .LAST_ADDR(8'h87)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .dout(dout), .din(din),
    .wr_en(wr_en), .rd_en(rd_en), .scl_i(scl_line), .sda_i(sda_line),
    .sda_oe(sda_oe), .scl_oe(scl_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) oe_cnt <= oe_cnt + {31'd0, sda_oe};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_v(input string t, input logic [7:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic observe(input logic [7:0] obs);
    logic [7:0] e;
    string      t;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required a queued expectation", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", t, obs, e);
      end
    end
  endtask

  task automatic check(input string t, input logic [7:0] obs, input logic [7:0] e);
    expect_v(t, e);
    observe(obs);
  endtask

  task automatic waitc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; dout = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, input string t, input logic [7:0] e);
    expect_v(t, e);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    observe(din);
  endtask

  task automatic wait_scl_high();
    int unsigned k = 0;
    while (scl_line !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    assert (scl_line === 1'b1) n_pass++;
    else begin
      n_fail++;
      $error("FAIL scl_release: observed scl %b required 1 within 400 clk", scl_line);
    end
  endtask

  task automatic m_start();
    m_sda = 1'b0; m_scl = 1'b0; waitc(6);
    m_sda = 1'b1; waitc(6);
    m_scl = 1'b1; waitc(3);
  endtask

  task automatic m_stop();
    m_sda = 1'b1; waitc(6);
    m_scl = 1'b0; wait_scl_high(); waitc(6);
    m_sda = 1'b0; waitc(6);
  endtask

  task automatic send_bit(input logic b);
    m_sda = ~b; waitc(6);
    m_scl = 1'b0; wait_scl_high(); waitc(6);
    m_scl = 1'b1; waitc(3);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b0; waitc(6);
    m_scl = 1'b0; wait_scl_high(); waitc(3);
    b = sda_line; waitc(3);
    m_scl = 1'b1; waitc(3);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  initial begin
    logic       b;
    logic [7:0] txv;
    int unsigned oe0;

    reset_n = 1'b0; addr = 8'h84; dout = '0; wr_en = 1'b0; rd_en = 1'b0;
    m_scl = 1'b0; m_sda = 1'b0;
    waitc(3);
    check("reset_din", din, 8'h00);
    check("reset_sda_oe", {7'd0, sda_oe}, 8'h00);
    check("reset_scl_oe", {7'd0, scl_oe}, 8'h00);
    reset_n = 1'b1;
    waitc(2);
    cpu_read(8'h84, "reset_con", 8'h20);
    @(negedge clk); addr = 8'h90; rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    n_chk++;
    assert (din === 8'hzz) n_pass++;
    else begin n_fail++; $error("FAIL din_outside: observed %h required zz", din); end

    // Master write: address 0x42 + W, data 0xA5
    cpu_write(8'h85, 8'h42);
    cpu_write(8'h86, 8'h3C);
    cpu_write(8'h84, 8'h03);
    cpu_read(8'h84, "con_setup", 8'h03);
    m_start();
    send_byte(8'h84);
    read_bit(b); check("wr_addr_ack", {7'd0, b}, 8'h00);
    send_byte(8'hA5);
    read_bit(b); check("wr_data_ack", {7'd0, b}, 8'h00);
    m_stop();
    cpu_read(8'h84, "con_rx_full", 8'h53);
    cpu_read(8'h87, "rx_byte", 8'hA5);
    cpu_read(8'h84, "con_after_rx", 8'h43);
    cpu_write(8'h84, 8'h43);

    // Non-matching address 0x43 is ignored without touching SDA
    oe0 = oe_cnt;
    m_start();
    send_byte(8'h86);
    read_bit(b); check("nomatch_nack", {7'd0, b}, 8'h01);
    check("nomatch_no_oe", 8'(oe_cnt - oe0), 8'h00);
    cpu_read(8'h84, "nomatch_con", 8'h03);
    m_stop();
    cpu_read(8'h84, "nomatch_con_stop", 8'h03);

    // Master read of 0x3C, master NACKs
    txv = 8'h3C;
    m_start();
    send_byte(8'h85);
    read_bit(b); check("rd_addr_ack", {7'd0, b}, 8'h00);
    for (int i = 7; i >= 0; i--) expect_v("tx_bit", {7'd0, txv[i]});
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      observe({7'd0, b});
    end
    send_bit(1'b1);
    m_stop();
    cpu_read(8'h84, "con_after_tx", 8'h6B);
    cpu_write(8'h84, 8'h43);

    // Two bytes without a CPU read of IICSRX
    m_start();
    send_byte(8'h84);
    read_bit(b); check("ovr_addr_ack", {7'd0, b}, 8'h00);
    send_byte(8'h11);
    read_bit(b); check("ovr_first_ack", {7'd0, b}, 8'h00);
    send_byte(8'h22);
    waitc(8);
`ifdef IICS_CLK_STRETCH_EN
    check("stretch_scl_oe", {7'd0, scl_oe}, 8'h01);
    cpu_read(8'h87, "stretch_rx_first", 8'h11);
    read_bit(b); check("stretch_second_ack", {7'd0, b}, 8'h00);
    check("stretch_released", {7'd0, scl_oe}, 8'h00);
    m_stop();
    cpu_read(8'h84, "stretch_con", 8'h73);
    cpu_read(8'h87, "stretch_rx_second", 8'h22);
`else
    check("no_stretch_scl_oe", {7'd0, scl_oe}, 8'h00);
    read_bit(b); check("ovr_second_nack", {7'd0, b}, 8'h01);
    m_stop();
    cpu_read(8'h84, "ovr_con", 8'hF3);
    cpu_read(8'h87, "ovr_rx", 8'h11);
`endif
    cpu_write(8'h84, 8'hC3);

    // Reset while the address ACK is being driven
    m_start();
    send_byte(8'h84);
    waitc(6);
    check("pre_reset_ack_drive", {7'd0, sda_oe}, 8'h01);
    reset_n = 1'b0;
    #1;
    check("async_reset_sda_oe", {7'd0, sda_oe}, 8'h00);
    check("async_reset_scl_oe", {7'd0, scl_oe}, 8'h00);
    waitc(2);
    reset_n = 1'b1;
    waitc(2);
    cpu_write(8'h85, 8'h42);
    cpu_write(8'h84, 8'h03);
    m_start();
    send_byte(8'h84);
    read_bit(b); check("post_reset_ack", {7'd0, b}, 8'h00);
    m_stop();
    cpu_read(8'h84, "post_reset_con", 8'h63);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
